uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU data-memory port, alongside the data RAM. It accepts byte stores into a TX FIFO and serialises them as 8N1 frames on `txd`. It returns a status word on loads, with one-cycle read latency to match the CPU's EXEC-issue / MEM-sample load sequence. Address decode of the peripheral window is internal; `hit` tells the data-bus mux to select `q` over RAM data.

---
 rtl/uart_tx_mmio.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte TX FIFO and a status register.
// The register window is 16 bytes at BASE_ADDR. Offset 0 (TXDATA) takes byte
// stores. Offset 1 (STATUS) returns {count, ovf, busy, empty, full}.
// Reads are registered, giving one cycle of latency; hit tells the bus mux to select q.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] addr,
   input  logic [31:0] d,
   input  logic [3:0]  we,
   output logic [31:0] q,
   output logic        hit,
   output logic        txd
);

   localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [8:0]  DEPTH_CNT = 9'(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e          state_q, state_d;
   logic [15:0]     baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            txd_q, txd_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [8:0]      count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [31:0]     q_q, q_d;
   logic            hit_q, hit_d;
   logic [7:0]      fifo_mem_q [FIFO_DEPTH];

   logic            sel, rd, wr_tx, push, pop, full, empty, busy, baud_last;
   logic [1:0]      offset;
   logic [7:0]      head;
   logic [31:0]     status;
   logic            unused_bits;

   assign unused_bits = ^{d[31:8], addr[1:0]};

   // Address decode, FIFO flags and the status word.
   always_comb begin
      sel       = en && (addr[31:4] == BASE_ADDR[31:4]);
      offset    = addr[3:2];
      rd        = sel && (we == 4'b0000);
      wr_tx     = sel && (offset == 2'd0) && we[0];
      full      = (count_q == DEPTH_CNT);
      empty     = (count_q == 9'd0);
      busy      = (state_q != IDLE);
      push      = wr_tx && !full;
      head      = fifo_mem_q[rd_ptr_q];
      baud_last = (baud_q == BAUD_LAST);
      status    = {19'b0, count_q, ovf_q, busy, empty, full};
   end

   // Bus side: read-data capture, hit flag and sticky overflow.
   always_comb begin
      q_d   = q_q;
      hit_d = sel;
      ovf_d = ovf_q;
      if (rd) begin
         q_d = (offset == 2'd1) ? status : '0;
      end
      if (wr_tx && full) begin
         ovf_d = 1'b1;
      end else if (rd && (offset == 2'd1)) begin
         ovf_d = 1'b0;
      end
   end

   // Transmit FSM: next state, baud/bit counters, shifter and popping the FIFO.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shreg_d   = head;
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = START;
            end
         end
         START: begin
            baud_d = baud_q + 16'd1;
            if (baud_last) begin
               baud_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            baud_d = baud_q + 16'd1;
            if (baud_last) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         STOP: begin
            baud_d = baud_q + 16'd1;
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  pop       = 1'b1;
                  shreg_d   = head;
                  bit_idx_d = '0;
                  state_d   = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // txd is registered from the next state, so the line changes on the same edge as the state.
      unique case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   // FIFO pointers and occupancy; a same-cycle pop does not free room for the push.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 9'd1;
         2'b01:   count_d = count_q - 9'd1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= d[7:0];
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         q_q       <= '0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         q_q       <= q_d;
         hit_q     <= hit_d;
      end
   end

   assign q   = q_q;
   assign hit = hit_q;
   assign txd = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio with CLK_DIV=4 and FIFO_DEPTH=4.
// A table of bus accesses is applied to the idle peripheral. Hand-written sequences
// then cover frame timing, FIFO overflow, back-to-back frames and reset during a frame.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [31:0] addr;
   logic [31:0] d;
   logic [3:0]  we;
   logic [31:0] q;
   logic        hit;
   logic        txd;

   int errors = 0;
   int checks = 0;

   uart_tx_mmio #(
      .BASE_ADDR (BASE),
      .CLK_DIV   (4),
      .FIFO_DEPTH(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .addr (addr),
      .d    (d),
      .we   (we),
      .q    (q),
      .hit  (hit),
      .txd  (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] d;
      logic [31:0] exp_q;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One bus access: drive at negedge, return #1 after the capturing edge with the strobe released.
   task automatic bus(input logic e, input logic [31:0] a, input logic [3:0] w, input logic [31:0] dd);
      @(negedge clk);
      en = e; addr = a; we = w; d = dd;
      @(posedge clk);
      #1;
      en = 1'b0; we = 4'b0000;
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      logic [7:0] v;
      v = b;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return v[k-1];
   endfunction

   task automatic wait_idle(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
         if (q == 32'h0000_0002) done = 1'b1;
      end
      chk("drain_to_idle", {31'b0, done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      vecs[0]  = '{1'b1, BASE + 32'd4,  4'b0000, 32'd0,         32'h2, 1'b1};
      vecs[1]  = '{1'b1, BASE + 32'd4,  4'b1111, 32'hFFFF_FFFF, 32'h2, 1'b1};
      vecs[2]  = '{1'b1, BASE + 32'd16, 4'b0000, 32'd0,         32'h2, 1'b0};
      vecs[3]  = '{1'b0, BASE + 32'd4,  4'b0000, 32'd0,         32'h2, 1'b0};
      vecs[4]  = '{1'b1, BASE + 32'd8,  4'b1111, 32'hFFFF_FFFF, 32'h2, 1'b1};
      vecs[5]  = '{1'b1, BASE + 32'd0,  4'b0010, 32'h0000_0055, 32'h2, 1'b1};
      vecs[6]  = '{1'b1, BASE + 32'd4,  4'b0000, 32'd0,         32'h2, 1'b1};
      vecs[7]  = '{1'b1, BASE + 32'd0,  4'b0000, 32'd0,         32'h0, 1'b1};
      vecs[8]  = '{1'b1, BASE + 32'd4,  4'b0000, 32'd0,         32'h2, 1'b1};
      vecs[9]  = '{1'b1, BASE + 32'd12, 4'b0000, 32'd0,         32'h0, 1'b1};
      vecs[10] = '{1'b1, BASE + 32'd4,  4'b0000, 32'd0,         32'h2, 1'b1};
      vecs[11] = '{1'b1, 32'h0000_0004, 4'b0000, 32'd0,         32'h2, 1'b0};

      en = 1'b0; addr = '0; d = '0; we = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_txd", {31'b0, txd}, 32'd1);
      chk("reset_q", q, 32'd0);
      chk("reset_hit", {31'b0, hit}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Register access table on the idle peripheral
      for (int i = 0; i < 12; i++) begin
         bus(vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].d);
         chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
         chk($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      end

      // Single frame 0xA5: txd falls one edge after the store, 10 levels of 4 cycles
      bus(1'b1, BASE, 4'b0001, 32'h0000_00A5);
      chk("a5_store_edge_txd", {31'b0, txd}, 32'd1);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         chk($sformatf("a5_bit%0d_c%0d", k / 4, k % 4), {31'b0, txd},
             {31'b0, frame_bit(8'hA5, k / 4)});
      end
      bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
      chk("a5_last_stop_busy", q, 32'h0000_0006);
      bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
      chk("a5_idle_status", q, 32'h0000_0002);

      // Overflow: six stores into a depth-4 FIFO, first is popped at once, sixth dropped
      for (int i = 0; i < 6; i++) begin
         bus(1'b1, BASE, 4'b0001, 32'h10 + 32'(i));
      end
      bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
      chk("ovf_status1", q, 32'h0000_004D);
      bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
      chk("ovf_status2", q, 32'h0000_0045);
      wait_idle(400);

      // Push while the transmitter pops the single queued byte: count stays 1
      bus(1'b1, BASE, 4'b0001, 32'h0000_003C);
      bus(1'b1, BASE, 4'b0001, 32'h0000_00C3);
      bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
      chk("pushpop_status", q, 32'h0000_0014);
      bus(1'b1, BASE + 32'd8, 4'b0000, 32'd0);
      chk("base8_q", q, 32'd0);
      chk("base8_hit", {31'b0, hit}, 32'd1);
      @(posedge clk); #1;
      chk("base8_hit_drop", {31'b0, hit}, 32'd0);
      bus(1'b1, BASE + 32'd16, 4'b0000, 32'd0);
      chk("base16_hit", {31'b0, hit}, 32'd0);
      chk("base16_q_hold", q, 32'd0);
      wait_idle(400);

      // Back-to-back frames 0x01 then 0x80: second start bit exactly 40 cycles later
      bus(1'b1, BASE, 4'b0001, 32'h0000_0001);
      bus(1'b1, BASE, 4'b0001, 32'h0000_0080);
      chk("b2b_start0", {31'b0, txd}, 32'd0);
      for (int k = 1; k < 84; k++) begin
         logic e;
         @(posedge clk); #1;
         if (k < 40) e = frame_bit(8'h01, k / 4);
         else        e = frame_bit(8'h80, (k - 40) / 4);
         chk($sformatf("b2b_k%0d", k), {31'b0, txd}, {31'b0, e});
      end
      wait_idle(100);

      // Reset during data bit 3 of a 0x00 frame
      bus(1'b1, BASE, 4'b0001, 32'h0000_0000);
      repeat (17) begin
         @(posedge clk); #1;
      end
      chk("rst_bit3_low", {31'b0, txd}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_txd", {31'b0, txd}, 32'd1);
      chk("rst_async_q", q, 32'd0);
      chk("rst_async_hit", {31'b0, hit}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      bus(1'b1, BASE + 32'd4, 4'b0000, 32'd0);
      chk("rst_status", q, 32'h0000_0002);
      lows = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (txd !== 1'b1) lows++;
      end
      chk("rst_no_residual", 32'(lows), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
